// File: rtl/dll_pkg.sv
// Shared Data Link Layer definitions: DLCMSM states, FC DLLP codes, field layout,
// CRC-16 constants and a flow-control DLLP body decoder.
package dll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT1  = 2'd1,
        ST_INIT2  = 2'd2,
        ST_ACTIVE = 2'd3
    } dlcm_state_e;

    typedef enum logic [1:0] {
        FC_NONE   = 2'd0,
        FC_INIT1  = 2'd1,
        FC_INIT2  = 2'd2,
        FC_UPDATE = 2'd3
    } fc_kind_e;

    localparam int HDR_W  = 8;
    localparam int DATA_W = 12;
    localparam int DLLP_W = 48;

    localparam logic [7:0] TYPE_INITFC1_P   = 8'h40;
    localparam logic [7:0] TYPE_INITFC1_NP  = 8'h50;
    localparam logic [7:0] TYPE_INITFC1_CPL = 8'h60;
    localparam logic [7:0] TYPE_INITFC2_P   = 8'hC0;
    localparam logic [7:0] TYPE_INITFC2_NP  = 8'hD0;
    localparam logic [7:0] TYPE_INITFC2_CPL = 8'hE0;
    localparam logic [7:0] TYPE_UPDFC_P     = 8'h80;
    localparam logic [7:0] TYPE_UPDFC_NP    = 8'h90;
    localparam logic [7:0] TYPE_UPDFC_CPL   = 8'hA0;

    // Byte lane positions inside the 48-bit DLLP
    localparam int B0_LSB     = 0;
    localparam int B1_LSB     = 8;
    localparam int B2_LSB     = 16;
    localparam int B3_LSB     = 24;
    localparam int CRC_HI_LSB = 32;
    localparam int CRC_LO_LSB = 40;

    localparam logic [15:0] CRC_POLY = 16'h100B;
    localparam logic [15:0] CRC_SEED = 16'hFFFF;

    localparam logic [1:0] IDX_P   = 2'd0;
    localparam logic [1:0] IDX_NP  = 2'd1;
    localparam logic [1:0] IDX_CPL = 2'd2;

    typedef struct packed {
        fc_kind_e            kind;
        logic [1:0]          idx;
        logic [HDR_W-1:0]    hdr;
        logic [DATA_W-1:0]   data;
    } fc_dec_t;

    // Full-byte match on byte0, so any nonzero VC ID falls through to FC_NONE.
    function automatic fc_dec_t decode_fc(input logic [31:0] body);
        fc_dec_t    d;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        b0 = body[B0_LSB +: 8];
        b1 = body[B1_LSB +: 8];
        b2 = body[B2_LSB +: 8];
        b3 = body[B3_LSB +: 8];
        d.kind = FC_NONE;
        d.idx  = IDX_P;
        d.hdr  = {b1[5:0], b2[7:6]};
        d.data = {b2[3:0], b3};
        case (b0)
            TYPE_INITFC1_P:   begin d.kind = FC_INIT1;  d.idx = IDX_P;   end
            TYPE_INITFC1_NP:  begin d.kind = FC_INIT1;  d.idx = IDX_NP;  end
            TYPE_INITFC1_CPL: begin d.kind = FC_INIT1;  d.idx = IDX_CPL; end
            TYPE_INITFC2_P:   begin d.kind = FC_INIT2;  d.idx = IDX_P;   end
            TYPE_INITFC2_NP:  begin d.kind = FC_INIT2;  d.idx = IDX_NP;  end
            TYPE_INITFC2_CPL: begin d.kind = FC_INIT2;  d.idx = IDX_CPL; end
            TYPE_UPDFC_P:     begin d.kind = FC_UPDATE; d.idx = IDX_P;   end
            TYPE_UPDFC_NP:    begin d.kind = FC_UPDATE; d.idx = IDX_NP;  end
            TYPE_UPDFC_CPL:   begin d.kind = FC_UPDATE; d.idx = IDX_CPL; end
            default:          begin d.kind = FC_NONE;   d.idx = IDX_P;   end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dllp_fc_rx_if.sv
// DLLP receive beat channel: valid/ready handshake carrying one DLLP per beat.
interface dllp_fc_rx_if;
    logic         dllp_valid_i;
    logic         dllp_ready_o;
    logic [255:0] dllp_data_i;

    modport master (output dllp_valid_i, output dllp_data_i, input dllp_ready_o);
    modport slave  (input dllp_valid_i, input dllp_data_i, output dllp_ready_o);
endinterface

// File: rtl/dllp_crc16.sv
// Combinational DLLP CRC-16 over bytes 0-3, byte0 first and LSB first per byte;
// output is the complemented remainder. Shared with the DLLP transmitter.
module dllp_crc16
    import dll_pkg::*;
(
    input  logic [31:0] data_i,
    output logic [15:0] crc_o
);

    logic [15:0] rem;
    logic        fb;

    always_comb begin
        rem = CRC_SEED;
        fb  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            fb  = rem[15] ^ data_i[i];
            rem = {rem[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        crc_o = ~rem;
    end

endmodule

// File: rtl/dllp_fc_rx.sv
// Receive-side flow-control DLLP decoder: two-stage beat pipeline, CRC check,
// partner credit limit tracking and the receive half of DLCMSM.
module dllp_fc_rx
    import dll_pkg::*;
#(
    parameter bit CRC_CHECK = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               link_up_i,
    input  logic               fc1_tx_done_i,
    input  logic               fc2_tx_done_i,
    dllp_fc_rx_if.slave        dllp,
    output logic [1:0]         state_o,
    output logic [HDR_W-1:0]   p_hdr_lim_o,
    output logic [HDR_W-1:0]   np_hdr_lim_o,
    output logic [HDR_W-1:0]   cpl_hdr_lim_o,
    output logic [DATA_W-1:0]  p_data_lim_o,
    output logic [DATA_W-1:0]  np_data_lim_o,
    output logic [DATA_W-1:0]  cpl_data_lim_o,
    output logic [2:0]         fc1_rx_flags_o,
    output logic               crc_err_o,
    output logic [7:0]         crc_err_cnt_o
);

    dlcm_state_e         state_q, state_d;
    logic                s1_vld_q, s1_vld_d;
    logic [DLLP_W-1:0]   s1_dat_q, s1_dat_d;
    logic [2:0]          flags_q, flags_d;
    logic                fi2_q, fi2_d;
    logic                crc_err_q, crc_err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic                ready;
    logic                accept;
    logic                clear;
    logic                live;
    logic                good;
    logic                bad;
    logic                crc_ok;
    logic [15:0]         crc_calc;
    logic [15:0]         crc_rx;
    fc_dec_t             dec;
    logic [2:0]          cap;
    logic [2:0]          upd;
    logic                unused_bits;

    assign unused_bits = ^dllp.dllp_data_i[255:DLLP_W];

    assign ready             = (state_q != ST_IDLE);
    assign dllp.dllp_ready_o = ready;
    // A beat offered while the link is dropping is never captured.
    assign accept            = dllp.dllp_valid_i & ready & link_up_i;
    assign clear             = !link_up_i || (state_q == ST_IDLE);

    dllp_crc16 u_crc (
        .data_i (s1_dat_q[31:0]),
        .crc_o  (crc_calc)
    );

    assign crc_rx = {s1_dat_q[CRC_HI_LSB +: 8], s1_dat_q[CRC_LO_LSB +: 8]};
    assign crc_ok = !CRC_CHECK || (crc_rx == crc_calc);
    assign dec    = decode_fc(s1_dat_q[31:0]);
    assign live   = s1_vld_q && !clear;
    assign good   = live && (dec.kind != FC_NONE) && crc_ok;
    assign bad    = live && (dec.kind != FC_NONE) && !crc_ok;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (link_up_i) state_d = ST_INIT1;
            ST_INIT1:  if ((flags_q == 3'b111) && fc1_tx_done_i) state_d = ST_INIT2;
            ST_INIT2:  if (fi2_q && fc2_tx_done_i) state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_ACTIVE;
            default:   state_d = ST_IDLE;
        endcase
        if (!link_up_i) state_d = ST_IDLE;
    end

    always_comb begin
        s1_vld_d  = accept;
        s1_dat_d  = accept ? dllp.dllp_data_i[DLLP_W-1:0] : s1_dat_q;
        flags_d   = flags_q | cap;
        fi2_d     = fi2_q | (good && (state_q == ST_INIT2) &&
                             ((dec.kind == FC_INIT2) || (dec.kind == FC_UPDATE)));
        crc_err_d = bad;
        err_cnt_d = err_cnt_q;
        if (bad && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        if (clear) begin
            flags_d   = 3'b000;
            fi2_d     = 1'b0;
            crc_err_d = 1'b0;
            err_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            s1_vld_q  <= 1'b0;
            s1_dat_q  <= '0;
            flags_q   <= 3'b000;
            fi2_q     <= 1'b0;
            crc_err_q <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            s1_vld_q  <= s1_vld_d;
            s1_dat_q  <= s1_dat_d;
            flags_q   <= flags_d;
            fi2_q     <= fi2_d;
            crc_err_q <= crc_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // One limit pair per credit type (0 P, 1 NP, 2 Cpl).
    for (genvar gi = 0; gi < 3; gi++) begin : g_lim
        logic [HDR_W-1:0]  hdr_q;
        logic [DATA_W-1:0] data_q;

        assign cap[gi] = good && (dec.kind == FC_INIT1) && (dec.idx == 2'(gi)) &&
                         (state_q == ST_INIT1) && !flags_q[gi];
        assign upd[gi] = good && (dec.kind == FC_UPDATE) && (dec.idx == 2'(gi)) &&
                         (state_q == ST_ACTIVE);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hdr_q  <= '0;
                data_q <= '0;
            end else if (clear) begin
                hdr_q  <= '0;
                data_q <= '0;
            end else if (cap[gi] || upd[gi]) begin
                hdr_q  <= dec.hdr;
                data_q <= dec.data;
            end
        end
    end

    assign state_o        = state_q;
    assign p_hdr_lim_o    = g_lim[0].hdr_q;
    assign np_hdr_lim_o   = g_lim[1].hdr_q;
    assign cpl_hdr_lim_o  = g_lim[2].hdr_q;
    assign p_data_lim_o   = g_lim[0].data_q;
    assign np_data_lim_o  = g_lim[1].data_q;
    assign cpl_data_lim_o = g_lim[2].data_q;
    assign fc1_rx_flags_o = flags_q;
    assign crc_err_o      = crc_err_q;
    assign crc_err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_dllp_fc_rx.sv
// Directed bench for dllp_fc_rx: init handshake, CRC errors, limit updates,
// link drop with traffic in flight and error counter saturation.
module tb_dllp_fc_rx;

    logic        clk;
    logic        rst_n;
    logic        link_up;
    logic        fc1_done;
    logic        fc2_done;
    logic [1:0]  state;
    logic [7:0]  p_hdr, np_hdr, cpl_hdr;
    logic [11:0] p_data, np_data, cpl_data;
    logic [2:0]  flags;
    logic        crc_err;
    logic [7:0]  err_cnt;

    int checks   = 0;
    int failures = 0;

    dllp_fc_rx_if bus ();

    dllp_fc_rx #(.CRC_CHECK(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .link_up_i      (link_up),
        .fc1_tx_done_i  (fc1_done),
        .fc2_tx_done_i  (fc2_done),
        .dllp           (bus),
        .state_o        (state),
        .p_hdr_lim_o    (p_hdr),
        .np_hdr_lim_o   (np_hdr),
        .cpl_hdr_lim_o  (cpl_hdr),
        .p_data_lim_o   (p_data),
        .np_data_lim_o  (np_data),
        .cpl_data_lim_o (cpl_data),
        .fc1_rx_flags_o (flags),
        .crc_err_o      (crc_err),
        .crc_err_cnt_o  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC: seed FFFF, poly 100B, bytes in order, LSB first, complemented.
    function automatic logic [15:0] crc_model(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0]  bytes [4];
        logic [15:0] c;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        c = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                if (c[15] != bytes[k][j]) c = (c << 1) ^ 16'h100B;
                else                      c = c << 1;
            end
        end
        return ~c;
    endfunction

    function automatic logic [47:0] mk(input logic [7:0] t, input logic [7:0] h,
                                       input logic [11:0] d, input bit bad);
        logic [7:0]  b0, b1, b2, b3, b4, b5;
        logic [15:0] c;
        b0 = t;
        b1 = {2'b00, h[7:2]};
        b2 = {h[1:0], 2'b00, d[11:8]};
        b3 = d[7:0];
        c  = crc_model(b0, b1, b2, b3);
        b4 = c[15:8];
        b5 = c[7:0];
        if (bad) b4 = b4 ^ 8'h01;
        return {b5, b4, b3, b2, b1, b0};
    endfunction

    // Beat is accepted at the posedge inside this task; returns at the following negedge.
    task automatic send(input logic [47:0] b);
        bus.dllp_valid_i = 1'b1;
        bus.dllp_data_i  = {208'h0, b};
        $display("beat t=%0t dllp=%h state=%0d", $time, b, state);
        @(negedge clk);
        bus.dllp_valid_i = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        link_up          = 1'b0;
        fc1_done         = 1'b0;
        fc2_done         = 1'b0;
        bus.dllp_valid_i = 1'b0;
        bus.dllp_data_i  = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ready", 32'(bus.dllp_ready_o), 32'd0);
        chk("rst_p_hdr", 32'(p_hdr), 32'd0);
        chk("rst_cpl_data", 32'(cpl_data), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_crc_err", 32'(crc_err), 32'd0);
        chk("rst_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(bus.dllp_ready_o), 32'd0);

        link_up = 1'b1;
        @(negedge clk);
        chk("up_state", 32'(state), 32'd1);
        chk("up_ready", 32'(bus.dllp_ready_o), 32'd1);
        chk("up_np_hdr", 32'(np_hdr), 32'd0);

        // Corrupted InitFC1-P
        send(mk(8'h40, 8'h55, 12'h123, 1'b1));
        @(negedge clk);
        chk("bad_crc_pulse", 32'(crc_err), 32'd1);
        chk("bad_crc_cnt", 32'(err_cnt), 32'd1);
        chk("bad_crc_flags", 32'(flags), 32'd0);
        chk("bad_crc_p_hdr", 32'(p_hdr), 32'd0);
        @(negedge clk);
        chk("bad_crc_pulse_end", 32'(crc_err), 32'd0);

        send(mk(8'h40, 8'h20, 12'h080, 1'b0));
        @(negedge clk);
        chk("fc1p_flags", 32'(flags), 32'd1);
        chk("fc1p_hdr", 32'(p_hdr), 32'h20);
        chk("fc1p_data", 32'(p_data), 32'h080);
        chk("fc1p_no_err", 32'(crc_err), 32'd0);

        send(mk(8'h40, 8'h33, 12'h456, 1'b0));
        @(negedge clk);
        chk("fc1p_repeat_hdr", 32'(p_hdr), 32'h20);
        chk("fc1p_repeat_data", 32'(p_data), 32'h080);

        send(mk(8'h51, 8'h11, 12'h222, 1'b0));
        @(negedge clk);
        chk("vc1_flags", 32'(flags), 32'd1);
        chk("vc1_np_hdr", 32'(np_hdr), 32'd0);
        chk("vc1_no_err", 32'(crc_err), 32'd0);

        send(mk(8'h00, 8'h11, 12'h222, 1'b0));
        @(negedge clk);
        chk("type0_flags", 32'(flags), 32'd1);
        chk("type0_no_err", 32'(crc_err), 32'd0);
        chk("type0_cnt", 32'(err_cnt), 32'd1);

        send(mk(8'h80, 8'h99, 12'h999, 1'b0));
        @(negedge clk);
        chk("upd_in_init1", 32'(p_hdr), 32'h20);

        // NP and Cpl back to back with local InitFC1 already done
        fc1_done = 1'b1;
        bus.dllp_valid_i = 1'b1;
        bus.dllp_data_i  = {208'h0, mk(8'h50, 8'h10, 12'h000, 1'b0)};
        $display("beat t=%0t dllp=%h state=%0d", $time, bus.dllp_data_i[47:0], state);
        @(negedge clk);
        send(mk(8'h60, 8'h00, 12'h000, 1'b0));
        @(negedge clk);
        chk("fc1_all_flags", 32'(flags), 32'd7);
        chk("fc1_np_hdr", 32'(np_hdr), 32'h10);
        chk("fc1_np_data", 32'(np_data), 32'h000);
        chk("fc1_cpl_hdr", 32'(cpl_hdr), 32'h00);
        chk("fc1_state_n1", 32'(state), 32'd1);
        @(negedge clk);
        chk("init2_state_n2", 32'(state), 32'd2);

        send(mk(8'h50, 8'h77, 12'h777, 1'b0));
        @(negedge clk);
        chk("fc1_in_init2", 32'(np_hdr), 32'h10);

        fc2_done = 1'b1;
        send(mk(8'h90, 8'h05, 12'h005, 1'b0));
        @(negedge clk);
        chk("updnp_init2_state_n1", 32'(state), 32'd2);
        chk("updnp_init2_hdr", 32'(np_hdr), 32'h10);
        @(negedge clk);
        chk("active_state", 32'(state), 32'd3);
        chk("active_np_data", 32'(np_data), 32'h000);

        send(mk(8'hC0, 8'h66, 12'h666, 1'b0));
        @(negedge clk);
        chk("fc2_no_update", 32'(p_hdr), 32'h20);

        send(mk(8'h80, 8'h40, 12'h100, 1'b0));
        @(negedge clk);
        chk("updp_hdr", 32'(p_hdr), 32'h40);
        chk("updp_data", 32'(p_data), 32'h100);

        send(mk(8'hA0, 8'h08, 12'h7FF, 1'b0));
        @(negedge clk);
        chk("updcpl_hdr", 32'(cpl_hdr), 32'h08);
        chk("updcpl_data", 32'(cpl_data), 32'h7FF);

        send(mk(8'h90, 8'h44, 12'h444, 1'b1));
        @(negedge clk);
        chk("active_bad_cnt", 32'(err_cnt), 32'd2);
        chk("active_bad_np", 32'(np_hdr), 32'h10);

        // Link drops while one beat is in flight and another is offered
        bus.dllp_valid_i = 1'b1;
        bus.dllp_data_i  = {208'h0, mk(8'h90, 8'hAA, 12'hAAA, 1'b0)};
        $display("beat t=%0t dllp=%h state=%0d", $time, bus.dllp_data_i[47:0], state);
        @(negedge clk);
        link_up = 1'b0;
        bus.dllp_data_i = {208'h0, mk(8'h80, 8'hBB, 12'hBBB, 1'b0)};
        $display("beat t=%0t dllp=%h state=%0d", $time, bus.dllp_data_i[47:0], state);
        @(negedge clk);
        chk("down_state", 32'(state), 32'd0);
        chk("down_ready", 32'(bus.dllp_ready_o), 32'd0);
        chk("down_np_hdr", 32'(np_hdr), 32'd0);
        chk("down_p_hdr", 32'(p_hdr), 32'd0);
        chk("down_cpl_data", 32'(cpl_data), 32'd0);
        chk("down_flags", 32'(flags), 32'd0);
        chk("down_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        bus.dllp_valid_i = 1'b0;
        chk("down_np_hdr_later", 32'(np_hdr), 32'd0);
        chk("down_p_hdr_later", 32'(p_hdr), 32'd0);

        link_up  = 1'b1;
        fc1_done = 1'b0;
        fc2_done = 1'b0;
        @(negedge clk);
        chk("reup_state", 32'(state), 32'd1);
        chk("reup_flags", 32'(flags), 32'd0);

        // 256 corrupted beats back to back: counter must stop at 255
        bus.dllp_valid_i = 1'b1;
        bus.dllp_data_i  = {208'h0, mk(8'h60, 8'h01, 12'h001, 1'b1)};
        $display("beat t=%0t dllp=%h x256 state=%0d", $time, bus.dllp_data_i[47:0], state);
        repeat (256) @(negedge clk);
        bus.dllp_valid_i = 1'b0;
        chk("sat_cnt_255", 32'(err_cnt), 32'd255);
        @(negedge clk);
        chk("sat_cnt_hold", 32'(err_cnt), 32'd255);
        chk("sat_pulse", 32'(crc_err), 32'd1);
        @(negedge clk);
        chk("sat_pulse_end", 32'(crc_err), 32'd0);
        chk("sat_flags", 32'(flags), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dllp_fc_rx.md
# dllp_fc_rx

Receive-side Flow Control DLLP decoder for the Data Link Layer. It takes DLLP beats arriving from the EP side and CRC-checks them. It decodes InitFC1, InitFC2 and UpdateFC DLLPs for P, NP and Cpl on VC0, and holds the link partner's credit limits for the TL transmit gate. It also runs the receive half of DLCMSM (IDLE/INIT1/INIT2/ACTIVE), using "local transmit done" inputs from the DLLP transmitter.

## Interface
- CRC_CHECK, 1: 1 enables the CRC-16 check; 0 treats every CRC as good (bring-up only).
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- link_up_i  input  1  physical link up; low forces IDLE.
- fc1_tx_done_i  input  1  level: local InitFC1 P/NP/Cpl all sent at least once.
- fc2_tx_done_i  input  1  level: local InitFC2 P/NP/Cpl all sent at least once.
- dllp_valid_i  input  1  DLLP beat valid.
- dllp_ready_o  output  1  beat accepted when valid & ready.
- dllp_data_i  input  256  beat; one DLLP in [47:0], byte n = [8n+7:8n]; [255:48] ignored.
- state_o  output  2  0 IDLE, 1 INIT1, 2 INIT2, 3 ACTIVE.
- p_hdr_lim_o / np_hdr_lim_o / cpl_hdr_lim_o  output  8 each  partner header credit limit; 0 = infinite.
- p_data_lim_o / np_data_lim_o / cpl_data_lim_o  output  12 each  partner data credit limit; 0 = infinite.
- fc1_rx_flags_o  output  3  bit0 P, bit1 NP, bit2 Cpl InitFC1 received.
- crc_err_o  output  1  one-cycle pulse per discarded bad-CRC DLLP.
- crc_err_cnt_o  output  8  saturating bad-CRC count.

## Operation
- Type codes (byte0): InitFC1 P/NP/Cpl = 0x40/0x50/0x60, InitFC2 = 0xC0/0xD0/0xE0, UpdateFC = 0x80/0x90/0xA0.
  - Byte0[2:0] is the VC ID. Nonzero VC: discarded silently. Any other type: discarded silently, no error.
- Fields:
  - HdrFC[7:2] = byte1[5:0], HdrFC[1:0] = byte2[7:6].
  - DataFC[11:8] = byte2[3:0], DataFC[7:0] = byte3.
- CRC: polynomial 0x100B, seed 0xFFFF, over bytes 0–3.
  - Byte0 is processed first, LSB first within each byte.
  - The remainder is complemented. Expected byte4 = rem[15:8], byte5 = rem[7:0].
- dllp_ready_o = 1 in INIT1/INIT2/ACTIVE, 0 in IDLE. There is no other backpressure.
- FSM:
  - IDLE→INIT1 when link_up_i.
  - INIT1→INIT2 when fc1_rx_flags_o == 3'b111 and fc1_tx_done_i.
  - INIT2→ACTIVE when fi2 (internal flag) and fc2_tx_done_i. fi2 is set by any good InitFC2 or UpdateFC received in INIT2.
  - Any state→IDLE when !link_up_i.
- INIT1: the first good InitFC1 of each type captures that type's hdr/data limits and sets its flag. Repeats of the same type are ignored; the first capture is kept.
- InitFC1 in INIT2/ACTIVE: ignored. InitFC2 in any state: no limit update.
- UpdateFC: overwrites that type's limits only in ACTIVE. In INIT2 it only sets fi2. In INIT1 it is ignored.
- Entry to IDLE (and reset) clears all limits, flags, fi2, crc_err_o and crc_err_cnt_o.

## Timing
- Stage 1: the accepted beat ([47:0]) is registered at edge N.
- Stage 2: CRC check and decode of the stage-1 register. Limits, flags, crc_err_o and the counter update at edge N+1.
- A state transition caused by that DLLP happens at edge N+2. Back-to-back beats are accepted every cycle.
- Reset values: state_o 0, all limits 0, fc1_rx_flags_o 0, crc_err_o 0, crc_err_cnt_o 0. dllp_ready_o is 0 while link_up_i is low.
- link_up_i falling with a beat in flight:
  - The in-flight beat is dropped, and IDLE plus all clears take effect at the next edge.
  - A beat accepted at the same edge is dropped.
- Link re-up: INIT1 is entered one edge after IDLE, with all flags clear.
- crc_err_cnt_o saturates at 255. crc_err_o still pulses at saturation.

## Structure
- Shared package dll_pkg: DLCMSM state enum; DLLP type code constants; field bit positions; CRC polynomial and seed; credit field widths (HDR_W = 8, DATA_W = 12).
- Sub-module dllp_crc16: combinational 32-bit-in / 16-bit-out CRC. It is reused by the DLLP transmitter.

## Test plan
- Reset, then link_up_i = 1 → state_o = 1 at the next edge; dllp_ready_o = 1; all limits 0.
- In INIT1, good InitFC1-P (hdr 0x20, data 0x080), NP (0x10, 0x000) and Cpl (0x00, 0x000), then fc1_tx_done_i = 1:
  - Flags reach 3'b111 and the limits match the sent values.
  - state_o = 2, two edges after the last beat.
- InitFC1-P with one CRC byte flipped → crc_err_o pulses 1 cycle, count = 1, P flag stays 0. A second InitFC1-P with different values after a good capture → limits unchanged.
- In INIT2, UpdateFC-NP with fc2_tx_done_i = 1 → state_o = 3, NP limits unchanged. In ACTIVE, UpdateFC-P hdr 0x40 → p_hdr_lim_o = 0x40 at N+1.
- DLLP with VC = 1 or type 0x00 → no flag or limit change, no crc_err_o.
- Deassert link_up_i in ACTIVE with dllp_valid_i = 1 → state_o = 0, all limits/flags/count 0, dllp_ready_o = 0, beat dropped.
